// File: rtl/rsa_link_ctrl.sv
// rsa_link_ctrl: byte-stream controller between the UART and the mon_exp core.
//
// Parses framed commands from the UART receiver:
//   'K' (0x4B): BITLEN/8 bytes of n, then BITLEN/8 bytes of e, MSB-first.
//   'M' (0x4D): BITLEN/8 bytes of message, then a BRAM write, a mon_exp start,
//               and the result sent back MSB-first over the UART transmitter.
// New frames are locked out while computing or transmitting (dropped bytes set
// the sticky overrun flag), and a stalled frame is abandoned after RX_TIMEOUT
// idle cycles.
//
// Optional feature (macro RSA_LINK_NAK_EN): an unknown command byte in idle is
// answered with a single 0x15 byte. Without it, unknown bytes are ignored.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   rx_valid, rx_byte received-byte strobe and data
//   tx_busy           UART transmitter busy
//   tx_valid, tx_byte one-cycle transmit strobe and data
//   wr_addr, wr_data, wr_en  BRAM write port for the message word
//   exp_start         one-cycle start pulse to mon_exp
//   e, e_idx, n       exponent, index of its top set bit, modulus
//   mp_count          Montgomery iteration count (constant BITLEN)
//   exp_stop, ans     mon_exp done strobe and result
//   busy              high whenever the controller is not idle
//   overrun           sticky dropped-byte flag
module rsa_link_ctrl #(
    parameter int unsigned BITLEN     = 16,
    parameter int unsigned LOG_BITLEN = 4,
    parameter int unsigned ABITS      = 8,
    parameter int unsigned DBITS      = BITLEN,
    parameter int unsigned MSG_ADDR   = 0,
    parameter int unsigned RX_TIMEOUT = 120000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_byte,
    input  logic                  tx_busy,
    output logic                  tx_valid,
    output logic [7:0]            tx_byte,
    output logic [ABITS-1:0]      wr_addr,
    output logic [DBITS-1:0]      wr_data,
    output logic                  wr_en,
    output logic                  exp_start,
    output logic [BITLEN-1:0]     e,
    output logic [LOG_BITLEN-1:0] e_idx,
    output logic [BITLEN-1:0]     n,
    output logic [LOG_BITLEN:0]   mp_count,
    input  logic                  exp_stop,
    input  logic [BITLEN-1:0]     ans,
    output logic                  busy,
    output logic                  overrun
);

    localparam int unsigned NB = BITLEN / 8;
    localparam int unsigned CW = (NB > 1) ? $clog2(NB) : 1;
    localparam int unsigned TW = $clog2(RX_TIMEOUT) + 1;
    localparam logic [CW-1:0] LAST = CW'(NB - 1);
    localparam logic [TW-1:0] TO_LAST = TW'(RX_TIMEOUT - 1);
    localparam logic [7:0] CMD_KEY = 8'h4B;
    localparam logic [7:0] CMD_MSG = 8'h4D;
`ifdef RSA_LINK_NAK_EN
    localparam logic [7:0] NAK_BYTE = 8'h15;
`endif

    typedef enum logic [3:0] {
        StIdle, StKeyN, StKeyE, StScan, StMsg, StWrite, StStart, StWait,
        StTxLoad, StTxSend, StTxGuard, StTxWait
    } state_t;

    state_t            state;
    logic [BITLEN-1:0] shreg;
    logic [BITLEN-1:0] shreg_in;
    logic [CW-1:0]     cnt;       // rx byte count, scan byte index, tx byte count
    logic [TW-1:0]     to_cnt;
    logic [7:0]        scan_byte;
    logic              rx_state;

    function automatic logic [2:0] msb8(input logic [7:0] b);
        logic [2:0] p;
        p = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = 3'(i);
        end
        return p;
    endfunction

    assign shreg_in  = {shreg[BITLEN-9:0], rx_byte};
    assign scan_byte = e[{cnt, 3'b000} +: 8];
    assign mp_count  = (LOG_BITLEN + 1)'(BITLEN);
    assign busy      = (state != StIdle);

    always_comb begin
        rx_state = (state inside {StIdle, StKeyN, StKeyE, StMsg});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            shreg     <= '0;
            cnt       <= '0;
            to_cnt    <= '0;
            n         <= '0;
            e         <= '0;
            e_idx     <= '0;
            overrun   <= 1'b0;
            tx_valid  <= 1'b0;
            tx_byte   <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            exp_start <= 1'b0;
        end else begin
            tx_valid  <= 1'b0;
            wr_en     <= 1'b0;
            exp_start <= 1'b0;
            // Frame states handle their own bytes; a byte lost to a timeout is not an overrun.
            if (rx_valid && !rx_state) overrun <= 1'b1;

            unique case (state)
                StIdle: begin
                    if (rx_valid) begin
                        cnt    <= '0;
                        to_cnt <= '0;
                        if (rx_byte == CMD_KEY) begin
                            state <= StKeyN;
                        end else if (rx_byte == CMD_MSG) begin
                            state <= StMsg;
                        end
`ifdef RSA_LINK_NAK_EN
                        else begin
                            // Single-byte reply reusing the result transmit path.
                            shreg <= {NAK_BYTE, {(BITLEN - 8){1'b0}}};
                            cnt   <= LAST;
                            state <= StTxLoad;
                        end
`endif
                    end
                end
                StKeyN, StKeyE, StMsg: begin
                    if (to_cnt == TO_LAST) begin
                        state <= StIdle;
                    end else if (rx_valid) begin
                        to_cnt <= '0;
                        shreg  <= shreg_in;
                        cnt    <= cnt + 1'b1;
                        if (cnt == LAST) begin
                            cnt <= '0;
                            case (state)
                                StKeyN: begin
                                    n     <= shreg_in;
                                    state <= StKeyE;
                                end
                                StKeyE: begin
                                    e     <= shreg_in;
                                    cnt   <= LAST;  // scan starts at the top byte
                                    state <= StScan;
                                end
                                default: begin
                                    wr_en   <= 1'b1;
                                    wr_addr <= ABITS'(MSG_ADDR);
                                    wr_data <= DBITS'(shreg_in);
                                    state   <= StWrite;
                                end
                            endcase
                        end
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                StScan: begin
                    if (scan_byte != 8'h00) begin
                        e_idx <= LOG_BITLEN'({cnt, msb8(scan_byte)});
                        state <= StIdle;
                    end else if (cnt == '0) begin
                        e_idx <= '0;
                        state <= StIdle;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                StWrite: begin
                    exp_start <= 1'b1;
                    state     <= StStart;
                end
                StStart: state <= StWait;
                StWait: begin
                    if (exp_stop) begin
                        shreg <= ans;
                        cnt   <= '0;
                        state <= StTxLoad;
                    end
                end
                StTxLoad: state <= StTxSend;
                StTxSend: begin
                    if (!tx_busy) begin
                        tx_valid <= 1'b1;
                        tx_byte  <= shreg[BITLEN-1 -: 8];
                        state    <= StTxGuard;
                    end
                end
                // Gives the UART a cycle to raise tx_busy after the strobe.
                StTxGuard: state <= StTxWait;
                StTxWait: begin
                    if (!tx_busy) begin
                        shreg <= {shreg[BITLEN-9:0], 8'h00};
                        if (cnt == LAST) begin
                            state <= StIdle;
                        end else begin
                            cnt   <= cnt + 1'b1;
                            state <= StTxSend;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_link_ctrl.sv
// Bench for rsa_link_ctrl (BITLEN=16, RX_TIMEOUT=50): a frame-level model
// predicts keys, BRAM writes, transmitted bytes and overrun; a per-cycle
// compare process checks the DUT against it, and literal checks pin the model.
module tb_rsa_link_ctrl;
    localparam int unsigned BITLEN = 16;
    localparam int unsigned NB = BITLEN / 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_byte = 8'h00;
    logic        tx_busy = 1'b0;
    logic        exp_stop = 1'b0;
    logic [15:0] ans = 16'h0000;
    logic        tx_valid, wr_en, exp_start, busy, overrun;
    logic [7:0]  tx_byte;
    logic [7:0]  wr_addr;
    logic [15:0] wr_data, e, n;
    logic [3:0]  e_idx;
    logic [4:0]  mp_count;

    rsa_link_ctrl #(
        .BITLEN(16), .LOG_BITLEN(4), .ABITS(8), .DBITS(16), .MSG_ADDR(0), .RX_TIMEOUT(50)
    ) dut (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_byte(rx_byte), .tx_busy(tx_busy),
        .tx_valid(tx_valid), .tx_byte(tx_byte), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_en(wr_en), .exp_start(exp_start), .e(e), .e_idx(e_idx), .n(n),
        .mp_count(mp_count), .exp_stop(exp_stop), .ans(ans), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_tx = -100;
    logic wr_en_d = 1'b0;

    // Frame-level model
    int          m_mode = 0;   // 0 idle, 1 key frame, 2 message frame
    int          m_cnt = 0;
    logic [63:0] m_acc = 0;
    logic [15:0] m_n = 0, m_e = 0;
    int          m_eidx = 0;
    logic        m_over = 1'b0;
    logic [7:0]  tx_q[$];
    logic [7:0]  tx_log[$];
    logic [23:0] wr_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_cnt = 0; m_acc = 0; m_n = 0; m_e = 0; m_eidx = 0; m_over = 1'b0;
        tx_q.delete();
        wr_q.delete();
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (m_mode == 0) begin
            m_cnt = 0;
            m_acc = 0;
            if (b == 8'h4B) m_mode = 1;
            else if (b == 8'h4D) m_mode = 2;
            else begin
`ifdef RSA_LINK_NAK_EN
                tx_q.push_back(8'h15);
`endif
            end
        end else begin
            m_acc = (m_acc << 8) | 64'(b);
            m_cnt++;
            if (m_mode == 1 && m_cnt == NB) m_n = m_acc[15:0];
            if (m_mode == 1 && m_cnt == 2 * NB) begin
                m_e = m_acc[15:0];
                m_eidx = 0;
                for (int i = 0; i < 16; i++) if (m_e[i]) m_eidx = i;
                m_mode = 0;
            end
            if (m_mode == 2 && m_cnt == NB) begin
                wr_q.push_back({8'h00, m_acc[15:0]});
                m_mode = 0;
            end
        end
    endtask

    task automatic step(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b, input bit drop);
        rx_valid = 1'b1;
        rx_byte  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        if (drop) m_over = 1'b1;
        else model_byte(b);
    endtask

    task automatic wait_idle(input int max, input string name);
        for (int i = 0; i < max && busy; i++) step(1);
        chk(name, busy, 0);
    endtask

    task automatic wait_tx(input int target, input int max, input string name);
        for (int i = 0; i < max && tx_log.size() < target; i++) step(1);
        chk(name, tx_log.size() >= target, 1);
    endtask

    task automatic finish_exp(input logic [15:0] a);
        exp_stop = 1'b1;
        ans = a;
        tx_q.push_back(a[15:8]);
        tx_q.push_back(a[7:0]);
        step(1);
        exp_stop = 1'b0;
        ans = 16'h0000;
    endtask

    // UART transmitter: busy for 8 cycles starting the cycle after a strobe.
    initial forever begin
        @(negedge clk);
        if (tx_valid) begin
            @(posedge clk);
            #1;
            tx_busy = 1'b1;
            repeat (8) @(posedge clk);
            #1;
            tx_busy = 1'b0;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            if (wr_en) begin
                if (wr_q.size() == 0) chk("wr_queue_size", wr_q.size(), 1);
                else chk("wr_addr_data", {wr_addr, wr_data}, wr_q.pop_front());
            end
            if (exp_start || wr_en_d) chk("exp_start_after_wr", exp_start, wr_en_d);
            if (tx_valid) begin
                chk("tx_valid_while_busy", tx_busy, 0);
                chk("tx_gap_ge3", (cyc - last_tx) >= 3, 1);
                last_tx = cyc;
                tx_log.push_back(tx_byte);
                if (tx_q.size() == 0) chk("tx_queue_size", tx_q.size(), 1);
                else chk("tx_byte", tx_byte, tx_q.pop_front());
            end
            if (!busy) begin
                chk("n", n, m_n);
                chk("e", e, m_e);
                chk("e_idx", e_idx, m_eidx);
            end
            chk("overrun", overrun, m_over);
            chk("mp_count", mp_count, 16);
        end
        wr_en_d = wr_en;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        model_reset();
        step(3);
        rst = 1'b0;
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_byte", tx_byte, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_exp_start", exp_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_n", n, 0);
        chk("rst_e", e, 0);
        chk("rst_e_idx", e_idx, 0);
        chk("rst_overrun", overrun, 0);

        // Key load
        send(8'h4B, 0); send(8'h00, 0); send(8'h0E, 0); send(8'h00, 0); send(8'h05, 0);
        wait_idle(4, "key1_idle_within_4");
        chk("key1_n", n, 16'h000E);
        chk("key1_e", e, 16'h0005);
        chk("key1_e_idx", e_idx, 2);

        // Message, with bytes dropped during WAIT and TX
        send(8'h4D, 0); send(8'h12, 0); send(8'h34, 0);
        chk("msg1_wr_en", wr_en, 1);
        chk("msg1_wr_addr", wr_addr, 0);
        chk("msg1_wr_data", wr_data, 16'h1234);
        step(1);
        chk("msg1_exp_start", exp_start, 1);
        chk("msg1_wr_en_off", wr_en, 0);
        step(3);
        send(8'h55, 1);
        chk("wait_overrun", overrun, 1);
        base = tx_log.size();
        finish_exp(16'hBEEF);
        wait_tx(base + 1, 50, "msg1_first_tx");
        send(8'h66, 1);
        wait_idle(200, "msg1_tx_done");
        chk("msg1_tx_count", tx_log.size() - base, 2);
        if (tx_log.size() >= base + 2) begin
            chk("msg1_tx0", tx_log[base], 8'hBE);
            chk("msg1_tx1", tx_log[base+1], 8'hEF);
        end

        // Stalled key frame is discarded
        send(8'h4B, 0); send(8'h00, 0);
        step(60);
        m_mode = 0;
        chk("timeout_idle", busy, 0);
        chk("timeout_n_kept", n, 16'h000E);
        chk("timeout_e_kept", e, 16'h0005);
        send(8'h4B, 0); send(8'h00, 0); send(8'h0B, 0); send(8'h00, 0); send(8'h81, 0);
        wait_idle(4, "key2_idle");
        chk("key2_n", n, 16'h000B);
        chk("key2_e", e, 16'h0081);
        chk("key2_e_idx", e_idx, 7);
        send(8'h4B, 0); send(8'h00, 0); send(8'h0B, 0); send(8'h80, 0); send(8'h00, 0);
        wait_idle(4, "key3_idle");
        chk("key3_e_idx_top", e_idx, 15);
        send(8'h4B, 0); send(8'h00, 0); send(8'h0B, 0); send(8'h00, 0); send(8'h00, 0);
        wait_idle(4, "key4_idle");
        chk("key4_e_idx_zero", e_idx, 0);

        // Unknown command
        base = tx_log.size();
        send(8'h7A, 0);
        step(30);
`ifdef RSA_LINK_NAK_EN
        chk("unknown_tx_count", tx_log.size() - base, 1);
`else
        chk("unknown_tx_count", tx_log.size() - base, 0);
`endif
        if (tx_log.size() > base) chk("unknown_nak_byte", tx_log[base], 8'h15);
        chk("unknown_idle", busy, 0);

        // Reset during TX_WAIT
        send(8'h4D, 0); send(8'hAB, 0); send(8'hCD, 0);
        step(4);
        base = tx_log.size();
        finish_exp(16'h5566);
        wait_tx(base + 1, 50, "msg2_first_tx");
        step(2);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        model_reset();
        chk("rst_mid_tx_valid", tx_valid, 0);
        chk("rst_mid_exp_start", exp_start, 0);
        chk("rst_mid_wr_en", wr_en, 0);
        chk("rst_mid_busy", busy, 0);
        for (int i = 0; i < 20 && tx_busy; i++) step(1);
        chk("uart_drained", tx_busy, 0);

        // New message after reset
        send(8'h4D, 0); send(8'h00, 0); send(8'h07, 0);
        chk("msg3_wr_data", wr_data, 16'h0007);
        step(3);
        base = tx_log.size();
        finish_exp(16'h0102);
        wait_idle(200, "msg3_tx_done");
        chk("msg3_tx_count", tx_log.size() - base, 2);
        if (tx_log.size() >= base + 2) begin
            chk("msg3_tx0", tx_log[base], 8'h01);
            chk("msg3_tx1", tx_log[base+1], 8'h02);
        end

        step(2);
        chk("tx_queue_drained", tx_q.size(), 0);
        chk("wr_queue_drained", wr_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
